collision_arbiter: RTL

//  Shares one background edge detector between both bikes by time-multiplexing it per frame.
//  - Even frames evaluate P1; odd frames evaluate P2.
//  - Latches and debounces the detector's hit output per player.
//  - Runs the round FSM (idle/run/resolve/over) and reports crash flags and the winner.
//  - Sits between the bike position/orientation registers, the edge detector and the game-state/display logic.

---
 rtl/collision_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/collision_arbiter.sv
// collision_arbiter: time-multiplexes one edge detector between two bikes
// (even frames P1, odd frames P2), debounces hits per player and runs the
// round FSM that reports crash flags and the winner.
// Optional feature macro: GRACE_PERIOD_EN (ignore hits for GRACE_FRAMES
// frames after each round start).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no round yet; waits for start
// RUN     | round live; detector alternates players every frame
// RESOLVE | one crash seen; one more frame evaluated for the other bike
// OVER    | round finished; flags/winner held, detector frozen
module collision_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int ORIENT_W     = 3,
  parameter int HIT_FRAMES   = 2,
  parameter int GRACE_FRAMES = 60
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic                frame_end,
  input  logic [ADDR_W-1:0]   p1_location,
  input  logic [ORIENT_W-1:0] p1_orient,
  input  logic [ADDR_W-1:0]   p2_location,
  input  logic [ORIENT_W-1:0] p2_orient,
  input  logic                edge_detected,
  output logic [ADDR_W-1:0]   det_location,
  output logic [ORIENT_W-1:0] det_orient,
  output logic                det_player,
  output logic [1:0]          state,
  output logic                p1_crash,
  output logic                p2_crash,
  output logic [1:0]          winner
);

  localparam int CNT_W = $clog2(HIT_FRAMES + 1);
  localparam logic [CNT_W-1:0] HIT_MAX = CNT_W'(HIT_FRAMES);

  // A zero debounce depth would make every frame a crash; refuse to build it.
  if (HIT_FRAMES < 1 || GRACE_FRAMES < 0) begin : g_bad_cfg
    $error("collision_arbiter: HIT_FRAMES must be >= 1 and GRACE_FRAMES >= 0");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RESOLVE = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             hit_flag;
  logic [CNT_W-1:0] p1_cnt, p2_cnt;
  logic [CNT_W-1:0] cur_cnt, next_cnt;
  logic             active, start_ok, eval, grace_active, hit_now, crash_now;
  logic             p1_crash_d, p2_crash_d;

`ifdef GRACE_PERIOD_EN
  localparam int GRACE_W = $clog2(GRACE_FRAMES + 1) + 1;
  logic [GRACE_W-1:0] grace_cnt;
  assign grace_active = (grace_cnt != '0);
`else
  assign grace_active = 1'b0;
`endif

  assign state    = state_q;
  assign active   = (state_q == S_RUN) || (state_q == S_RESOLVE);
  // start is only honoured outside a live round, and then it wins over frame_end.
  assign start_ok = start && !active;
  assign eval     = active && frame_end;

  // Debounce update for whichever player the detector looked at this frame.
  always_comb begin
    hit_now    = (hit_flag | edge_detected) & ~grace_active;
    cur_cnt    = det_player ? p2_cnt : p1_cnt;
    next_cnt   = '0;
    if (hit_now) next_cnt = (cur_cnt == HIT_MAX) ? cur_cnt : cur_cnt + CNT_W'(1);
    crash_now  = hit_now && (next_cnt == HIT_MAX);
    p1_crash_d = p1_crash | (eval & ~det_player & crash_now);
    p2_crash_d = p2_crash | (eval &  det_player & crash_now);
  end

  // Round FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_ok) state_d = S_RUN;
      S_RUN:     if (eval && crash_now) state_d = S_RESOLVE;
      S_RESOLVE: if (eval) state_d = S_OVER;
      S_OVER:    if (start_ok) state_d = S_RUN;
      default:   state_d = S_IDLE;
    endcase
  end

  // Round FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Detector drive, hit latch, per-player counters, crash flags and winner.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      det_location <= '0;
      det_orient   <= '0;
      det_player   <= 1'b0;
      hit_flag     <= 1'b0;
      p1_cnt       <= '0;
      p2_cnt       <= '0;
      p1_crash     <= 1'b0;
      p2_crash     <= 1'b0;
      winner       <= 2'b00;
    end else if (start_ok) begin
      det_location <= p1_location;
      det_orient   <= p1_orient;
      det_player   <= 1'b0;
      hit_flag     <= 1'b0;
      p1_cnt       <= '0;
      p2_cnt       <= '0;
      p1_crash     <= 1'b0;
      p2_crash     <= 1'b0;
      winner       <= 2'b00;
    end else if (eval) begin
      det_player   <= ~det_player;
      det_location <= det_player ? p1_location : p2_location;
      det_orient   <= det_player ? p1_orient : p2_orient;
      hit_flag     <= 1'b0;
      if (det_player) p2_cnt <= next_cnt;
      else            p1_cnt <= next_cnt;
      p1_crash     <= p1_crash_d;
      p2_crash     <= p2_crash_d;
      if (state_q == S_RESOLVE) winner <= {p1_crash_d, p2_crash_d};
    end else if (active && edge_detected && !grace_active) begin
      hit_flag     <= 1'b1;
    end
  end

`ifdef GRACE_PERIOD_EN
  // Grace frames left since round start; counts down on RUN frame ends.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                                   grace_cnt <= '0;
    else if (start_ok)                             grace_cnt <= GRACE_W'(GRACE_FRAMES);
    else if (eval && state_q == S_RUN && grace_active) grace_cnt <= grace_cnt - GRACE_W'(1);
  end
`endif

endmodule
